// File: rtl/instr_encoder.sv
// Program loader: packs instruction descriptions into MIPS words and writes
// them to instruction memory at consecutive addresses, one session at a time.
module instr_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_kind,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_shamt,
  input  logic [5:0]            in_funct,
  input  logic [15:0]           in_imm,
  input  logic                  in_last,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] BASE_W   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    FINISH
  } state_t;

  state_t                state;
  state_t                next;
  logic                  last_q;
  logic [31:0]           enc;
  logic [ADDR_WIDTH:0]   count_inc;

  assign count_inc = word_count + CNT_ONE;

  // Pack the presented fields into a MIPS word according to the kind.
  always_comb begin
    enc = '0;
    case (in_kind)
      2'd0: enc = {6'd0,  in_rs, in_rt, in_rd, in_shamt, in_funct};
      2'd1: enc = {6'd35, in_rs, in_rt, in_imm};
      2'd2: enc = {6'd43, in_rs, in_rt, in_imm};
      2'd3: enc = {6'd4,  in_rs, in_rt, in_imm};
      default: enc = '0;
    endcase
  end

  // State register; reset aborts any session at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // Next-state selection and the state-decoded handshake/status outputs.
  always_comb begin
    next     = state;
    in_ready = 1'b0;
    im_we    = 1'b0;
    done     = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) next = ACCEPT;
      end
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) next = WRITE;
      end
      WRITE: begin
        im_we = 1'b1;
        if (last_q || (count_inc == DEPTH_W)) next = FINISH;
        else                                 next = ACCEPT;
      end
      FINISH: begin
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Session datapath: address, captured word, word count and overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_addr    <= BASE_W;
      im_wdata   <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            im_addr    <= BASE_W;
            word_count <= '0;
            overflow   <= 1'b0;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            im_wdata <= enc;
            last_q   <= in_last;
          end
        end
        WRITE: begin
          word_count <= count_inc;
          // The address only advances when another word will follow, so it
          // never steps past the final written location.
          if (!last_q) begin
            if (count_inc == DEPTH_W) overflow <= 1'b1;
            else                      im_addr  <= im_addr + ADDR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Encoder counterpart of the main control decoder. It accepts instruction descriptions (kind plus register and immediate fields) over a valid/ready handshake and packs each into a 32-bit MIPS word. It writes the words into instruction memory at consecutive addresses. It is the program loader that feeds the single-cycle datapath from the testbench or a boot path.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width
DEPTH, 256, number of words available (must be <= 2**ADDR_WIDTH)
BASE_ADDR, 0, first word address written in each load session

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin a load session (sampled in IDLE only)
in_valid  input  1  instruction fields valid
in_ready  output  1  encoder can accept fields this cycle
in_kind  input  2  0=R-type, 1=lw, 2=sw, 3=beq
in_rs  input  5  rs field
in_rt  input  5  rt field
in_rd  input  5  rd field (R-type only)
in_shamt  input  5  shamt field (R-type only)
in_funct  input  6  funct field (R-type only)
in_imm  input  16  immediate/offset (lw, sw, beq)
in_last  input  1  this instruction ends the session
im_we  output  1  instruction-memory write strobe
im_addr  output  ADDR_WIDTH  instruction-memory word address
im_wdata  output  32  encoded instruction word
busy  output  1  session in progress (state != IDLE)
done  output  1  one-cycle pulse at session end
word_count  output  ADDR_WIDTH+1  words written in current/last session
overflow  output  1  sticky: session truncated because memory filled

Behaviour:
- Reset: state=IDLE; in_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, busy=0, done=0, word_count=0, overflow=0. Reset mid-session aborts immediately. No further im_we occurs.
- Encoding:
  - R-type = {6'd0, rs, rt, rd, shamt, funct}.
  - lw = {6'd35, rs, rt, imm}.
  - sw = {6'd43, rs, rt, imm}.
  - beq = {6'd4, rs, rt, imm}.
  - Fields not used by a kind are ignored.
- States: IDLE, ACCEPT, WRITE, FINISH.
- IDLE:
  - in_ready=0.
  - On start=1: im_addr<=BASE_ADDR, word_count<=0, overflow<=0, go ACCEPT.
- ACCEPT:
  - in_ready=1.
  - On in_valid&in_ready: register the encoded word into im_wdata and in_last into last_q, go WRITE.
  - Otherwise hold.
- WRITE:
  - in_ready=0; im_we=1 for exactly this cycle with current im_addr/im_wdata.
  - At the clock edge: word_count+=1.
  - If last_q: go FINISH.
  - Else if word_count+1==DEPTH: overflow<=1, go FINISH.
  - Else im_addr+=1, go ACCEPT.
- FINISH: done=1 for one cycle, then go IDLE. im_addr holds the last written address; word_count holds the final total.
- Timing: handshake in cycle N gives im_we in cycle N+1. Peak throughput is one word per 2 cycles.
- start is ignored outside IDLE. in_valid is ignored outside ACCEPT. Fields need only be stable in the handshake cycle.
- Address never wraps. A write beyond BASE_ADDR+DEPTH-1 never occurs.
- A session with in_last on the word that fills DEPTH ends normally with overflow=0.
- im_wdata holds its last value when im_we=0.

Test Plan:
- Reset, then start, then one R-type (rs=1, rt=2, rd=3, shamt=0, funct=0x20, last=1) -> one im_we pulse at addr 0 with data 0x00221820, the cycle after the handshake; done pulses 1 cycle later; word_count=1.
- Sequence lw(rs=0, rt=8, imm=4), sw(rs=0, rt=8, imm=8), beq(rs=8, rt=9, imm=0xFFFE, last) -> writes 0x8C080004 @0, 0xAC080008 @1, 0x1109FFFE @2; word_count=3, overflow=0.
- in_valid held low for 5 cycles in ACCEPT, with start asserted during the session -> in_ready stays 1, no im_we, no restart, address unchanged.
- DEPTH=4, six instructions with no last -> exactly 4 writes at addr 0..3; overflow=1, done pulses, in_ready stays 0 afterward. A new start clears overflow.
- Reset asserted asynchronously in the WRITE cycle -> im_we drops immediately; all outputs go to reset values; no write at the next edge.
- BASE_ADDR=16, two instructions, last on the 2nd -> writes at 16 and 17, word_count=2.
